// File: rtl/pool_stream_if.sv
// Pixel-in / pooled-pixel-out stream bundle for pool_stream.
// master = upstream/downstream driver side, slave = the pooling engine.
interface pool_stream_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pool_stream.sv
// Streaming KxK stride-K max/average pooling over a raster pixel stream,
// holding one band of partial window results (IMG_N/POOL_K entries).
module pool_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_N  = 4,
  parameter int POOL_K = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  pool_stream_if.slave s,
  output logic         busy
);
  localparam int KL    = $clog2(POOL_K);
  localparam int SH    = 2 * KL;
  localparam int ACC_W = DATA_W + SH;
  localparam int NB    = IMG_N / POOL_K;
  localparam int CW    = $clog2(IMG_N);
  localparam int IW    = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]            r_col, r_row;
  logic                     r_mode, r_busy;
  logic                     r_out_valid, r_out_last;
  logic signed [DATA_W-1:0] r_out_data;
  logic signed [ACC_W-1:0]  r_buf [NB];

  logic                     w_in_ready, w_acc, w_out_hs;
  logic                     w_first_px, w_last_px, w_win_first, w_win_done;
  logic [IW-1:0]            w_idx;
  logic signed [ACC_W-1:0]  w_px, w_old, w_comb, w_avg;
  logic signed [DATA_W-1:0] w_res;

  assign w_in_ready  = !rst && (!r_out_valid || s.out_ready);
  assign w_acc       = s.in_valid && w_in_ready;
  assign w_out_hs    = r_out_valid && s.out_ready;
  assign w_first_px  = (r_col == '0) && (r_row == '0);
  assign w_last_px   = (r_col == CW'(IMG_N-1)) && (r_row == CW'(IMG_N-1));
  assign w_win_first = (r_col[KL-1:0] == '0) && (r_row[KL-1:0] == '0);
  assign w_win_done  = (&r_col[KL-1:0]) && (&r_row[KL-1:0]);
  assign w_idx       = IW'(r_col >> KL);

  assign w_px  = ACC_W'(s.in_data);
  assign w_old = r_buf[w_idx];

  // The frame's first pixel always opens a window, so using the latched
  // mode here is safe even on the cycle the latch is being updated.
  always_comb begin
    w_comb = w_px;
    if (!w_win_first) begin
      if (r_mode)            w_comb = w_old + w_px;
      else if (w_old > w_px) w_comb = w_old;
    end
  end

  assign w_avg = w_comb >>> SH;
  assign w_res = r_mode ? w_avg[DATA_W-1:0] : w_comb[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_mode      <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_acc) begin
        if (r_col == CW'(IMG_N-1)) begin
          r_col <= '0;
          r_row <= (r_row == CW'(IMG_N-1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_first_px) r_mode <= mode;
      end
      // a new frame starting on the final handshake keeps busy asserted
      if (w_acc && w_first_px)         r_busy <= 1'b1;
      else if (w_out_hs && r_out_last) r_busy <= 1'b0;
      if (w_acc && w_win_done) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
        r_out_last  <= w_last_px;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_buf[w_idx] <= w_comb;
  end

  assign s.in_ready  = w_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.out_data  = r_out_data;
  assign s.out_last  = r_out_last;
  assign busy        = r_busy;
endmodule
